// File: rtl/usb_pattern_tester.sv
// usb_pattern_tester: drives a counter/LFSR word pattern into a transmit FIFO
// and checks the looped-back words popped from a receive FIFO.
// Optional build macro: PATTERN_TIMEOUT_EN adds an idle-receive timeout that
// ends a burst early and raises the timeout output.
module usb_pattern_tester #(
    parameter logic [31:0] SEED           = 32'h0000_0001,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [15:0] burst_len,
    input  logic        tx_ready,
    output logic        tx_write,
    output logic [31:0] tx_data,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    output logic        rx_read,
    output logic        busy,
    output logic        done,
    output logic [15:0] err_count,
    output logic        err_flag,
    output logic        timeout
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Right-shifting Galois taps for x^32 + x^22 + x^2 + x + 1
    localparam logic [DW-1:0] LFSR_TAPS = 32'h8020_0003;
    // An all-zero LFSR would lock up, so a zero seed starts at 1 in LFSR mode
    localparam logic [DW-1:0] SEED_LFSR = (SEED == 32'd0) ? 32'd1 : SEED;

    // One generator step for either pattern
    function automatic logic [DW-1:0] gen_next(input logic m, input logic [DW-1:0] w);
        if (m) begin
            return w[0] ? ((w >> 1) ^ LFSR_TAPS) : (w >> 1);
        end
        return w + 32'd1;
    endfunction

    logic [1:0]    state_q,   state_d;
    logic [CW-1:0] len_q,     len_d;
    logic          mode_q,    mode_d;
    logic [CW-1:0] tx_cnt_q,  tx_cnt_d;
    logic [CW-1:0] rx_cnt_q,  rx_cnt_d;
    logic [DW-1:0] tx_gen_q,  tx_gen_d;
    logic [DW-1:0] rx_gen_q,  rx_gen_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic          err_flg_q, err_flg_d;
`ifdef PATTERN_TIMEOUT_EN
    logic [23:0]   to_cnt_q,  to_cnt_d;
    logic          to_flg_q,  to_flg_d;
`endif

    // FIFO handshakes are combinational so one word can move per cycle
    assign tx_write  = (state_q == RUN) && tx_ready && (tx_cnt_q < len_q);
    assign rx_read   = (state_q == RUN) && rx_valid && (rx_cnt_q < len_q);
    assign tx_data   = tx_gen_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign err_count = err_cnt_q;
    assign err_flag  = err_flg_q;
`ifdef PATTERN_TIMEOUT_EN
    assign timeout   = to_flg_q;
`else
    assign timeout   = 1'b0;
    // Limit only matters when the timeout counter is built
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // Next-state, counter and generator update logic
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        mode_d    = mode_q;
        tx_cnt_d  = tx_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        tx_gen_d  = tx_gen_q;
        rx_gen_d  = rx_gen_q;
        err_cnt_d = err_cnt_q;
        err_flg_d = err_flg_q;
`ifdef PATTERN_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        to_flg_d  = to_flg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d     = burst_len;
                    mode_d    = mode;
                    tx_gen_d  = mode ? SEED_LFSR : SEED;
                    rx_gen_d  = mode ? SEED_LFSR : SEED;
                    tx_cnt_d  = '0;
                    rx_cnt_d  = '0;
                    err_cnt_d = '0;
                    err_flg_d = 1'b0;
`ifdef PATTERN_TIMEOUT_EN
                    to_cnt_d  = '0;
                    to_flg_d  = 1'b0;
`endif
                    state_d   = (burst_len != 16'd0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (tx_write) begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                    tx_gen_d = gen_next(mode_q, tx_gen_q);
                end
                if (rx_read) begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                    rx_gen_d = gen_next(mode_q, rx_gen_q);
                    if (rx_data != rx_gen_q) begin
                        err_flg_d = 1'b1;
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                    end
                end
`ifdef PATTERN_TIMEOUT_EN
                to_cnt_d = rx_read ? 24'd0 : (to_cnt_q + 24'd1);
                if (to_cnt_d == TIMEOUT_CYCLES) begin
                    to_flg_d = 1'b1;
                    state_d  = DONE;
                end
`endif
                if ((tx_cnt_d == len_q) && (rx_cnt_d == len_q)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            mode_q    <= 1'b0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            tx_gen_q  <= SEED;
            rx_gen_q  <= SEED;
            err_cnt_q <= '0;
            err_flg_q <= 1'b0;
`ifdef PATTERN_TIMEOUT_EN
            to_cnt_q  <= '0;
            to_flg_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_gen_q  <= tx_gen_d;
            rx_gen_q  <= rx_gen_d;
            err_cnt_q <= err_cnt_d;
            err_flg_q <= err_flg_d;
`ifdef PATTERN_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
            to_flg_q  <= to_flg_d;
`endif
        end
    end

endmodule

// File: tb/tb_usb_pattern_tester.sv
// Testbench for usb_pattern_tester: loopback FIFO model, pattern reference
// model, directed and randomized bursts, reset and zero-length cases.
module tb_usb_pattern_tester;

    localparam logic [31:0] SEED = 32'h0000_0000;
    localparam logic [23:0] TO   = 24'd16;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mode;
    logic [15:0] burst_len;
    logic        tx_ready;
    logic        tx_write;
    logic [31:0] tx_data;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        rx_read;
    logic        busy;
    logic        done;
    logic [15:0] err_count;
    logic        err_flag;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    usb_pattern_tester #(.SEED(SEED), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .burst_len(burst_len),
        .tx_ready(tx_ready), .tx_write(tx_write), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_read(rx_read),
        .busy(busy), .done(done), .err_count(err_count), .err_flag(err_flag),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference pattern: counter, or polynomial x^32+x^22+x^2+x+1 stepped as a
    // right-shifting Galois register (each exponent e contributes tap bit e-1)
    function automatic logic [31:0] ref_next(input logic m, input logic [31:0] w);
        int exps [4] = '{32, 22, 2, 1};
        logic [31:0] taps;
        if (!m) return w + 32'd1;
        taps = '0;
        foreach (exps[i]) taps[exps[i]-1] = 1'b1;
        return (w >> 1) ^ (w[0] ? taps : 32'h0);
    endfunction

    function automatic logic [31:0] ref_word(input logic m, input int k);
        logic [31:0] w;
        w = (m && SEED == 32'd0) ? 32'd1 : SEED;
        for (int i = 0; i < k; i++) w = ref_next(m, w);
        return w;
    endfunction

    // One burst through a loopback FIFO. rdy_mode: 0 always ready, 1 toggle, 2 random.
    // Word number corrupt_idx is flipped in bit 0 on its way through the FIFO.
    task automatic burst(input string tag, input logic m, input int len, input int corrupt_idx,
                         input int rdy_mode, input int stall_from, input int stall_len);
        logic [31:0] fifo [$];
        int  nw = 0;
        int  nr = 0;
        int  bad = 0;
        bit  seen_done = 0;
        logic [15:0] exp_err;
        exp_err = (corrupt_idx < len) ? 16'd1 : 16'd0;
        for (int cyc = 0; cyc < 2000 && !seen_done; cyc++) begin
            @(negedge clk);
            start     = (cyc == 0) || (cyc == 5);
            mode      = (cyc == 0) ? m : ~m;
            burst_len = (cyc == 0) ? 16'(len) : 16'd7;
            case (rdy_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cyc % 2 == 1);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            rx_valid = (fifo.size() > 0) && !(cyc >= stall_from && cyc < stall_from + stall_len);
            rx_data  = (fifo.size() > 0) ? fifo[0] : $urandom();
            #1;
            if (done) seen_done = 1;
            if (tx_write && !tx_ready) bad++;
            if (rx_read && !rx_valid) bad++;
            if (tx_write) begin
                check($sformatf("%s_tx%0d", tag, nw), tx_data, ref_word(m, nw));
                fifo.push_back((nw == corrupt_idx) ? (tx_data ^ 32'h1) : tx_data);
                nw++;
            end
            if (rx_read) begin
                void'(fifo.pop_front());
                nr++;
            end
        end
        start = 1'b0;
        check({tag, "_done"},      32'(seen_done), 32'd1);
        check({tag, "_writes"},    32'(nw), 32'(len));
        check({tag, "_reads"},     32'(nr), 32'(len));
        check({tag, "_handshake"}, 32'(bad), 32'd0);
        check({tag, "_errcnt"},    32'(err_count), 32'(exp_err));
        check({tag, "_errflag"},   32'(err_flag), 32'(exp_err != 16'd0));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check({tag, "_errcnt_hold"}, 32'(err_count), 32'(exp_err));
        check({tag, "_errflag_hold"}, 32'(err_flag), 32'(exp_err != 16'd0));
    endtask

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; mode = 1'b0; burst_len = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        #1;
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_done",    32'(done), 32'd0);
        check("rst_errcnt",  32'(err_count), 32'd0);
        check("rst_errflag", 32'(err_flag), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_txdata",  tx_data, SEED);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        tx_ready = 1'b1; rx_valid = 1'b1;
        // No activity after reset release without a start
        repeat (4) begin
            @(negedge clk);
            #1;
            check("idle_txw", 32'(tx_write), 32'd0);
            check("idle_rxr", 32'(rx_read), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end

        burst("cnt4",   1'b0, 4, 99, 0, 0, 0);
        burst("lfsr3",  1'b1, 3, 99, 0, 0, 0);
        burst("corrupt", 1'b0, 5, 1, 0, 0, 0);
        burst("lfsrbad", 1'b1, 6, 1, 0, 0, 0);
        burst("toggle", 1'b1, 8, 99, 1, 3, 10);
        for (int i = 0; i < 6; i++) begin
            int l;
            l = $urandom_range(1, 40);
            burst($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), l,
                  $urandom_range(0, l), 2, $urandom_range(0, 20), $urandom_range(0, 12));
        end

        // Zero length: done on the next cycle, no writes
        @(negedge clk);
        start = 1'b1; burst_len = 16'd0; mode = 1'b0; tx_ready = 1'b1; rx_valid = 1'b0;
        #1;
        check("len0_txw0", 32'(tx_write), 32'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("len0_done",  32'(done), 32'd1);
        check("len0_txw1",  32'(tx_write), 32'd0);
        check("len0_busy",  32'(busy), 32'd0);
        @(negedge clk);
        #1;
        check("len0_done_clr", 32'(done), 32'd0);

        // Receive side starved: timeout ends the burst, or it stays busy without it
        @(negedge clk);
        start = 1'b1; burst_len = 16'd4; mode = 1'b0; tx_ready = 1'b1; rx_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n = 0;
`ifdef PATTERN_TIMEOUT_EN
        for (int c = 0; c < 100; c++) begin
            #1;
            if (done) break;
            if (busy) n++;
            @(negedge clk);
        end
        check("to_done",    32'(done), 32'd1);
        check("to_flag",    32'(timeout), 32'd1);
        check("to_cycles",  32'(n), 32'(TO));
        @(negedge clk);
        #1;
        check("to_hold",    32'(timeout), 32'd1);
        check("to_idle",    32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b1; burst_len = 16'd20;
        @(negedge clk);
        start = 1'b0;
`else
        for (int c = 0; c < 40; c++) begin
            #1;
            if (busy) n++;
            @(negedge clk);
        end
        check("noto_busy",   32'(n), 32'd40);
        check("noto_flag",   32'(timeout), 32'd0);
`endif
        // Reset mid-burst: outputs clear at once, before any clock edge
        repeat (2) @(negedge clk);
        #1;
        check("mid_busy_pre", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_busy",    32'(busy), 32'd0);
        check("mid_txw",     32'(tx_write), 32'd0);
        check("mid_rxr",     32'(rx_read), 32'd0);
        check("mid_done",    32'(done), 32'd0);
        check("mid_errcnt",  32'(err_count), 32'd0);
        check("mid_errflag", 32'(err_flag), 32'd0);
        check("mid_timeout", 32'(timeout), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_txw",  32'(tx_write), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_pattern_tester.md
USB_PATTERN_TESTER -- requirements
Module: usb_pattern_tester

Interface
REQ-001 SHALL have parameter SEED, default 32'h0000_0001, initial word for both pattern generators.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 24'd1_000_000, idle-receive limit (used only with PATTERN_TIMEOUT_EN).
REQ-003 SHALL have the following ports, listed as name, direction, width, meaning:
  clk  in  1  single clock for all logic (FTDI 100 MHz domain).
  rst  in  1  asynchronous, active-low reset.
  start  in  1  single-cycle pulse that begins a burst.
  mode  in  1  pattern select: 0 = incrementing counter, 1 = 32-bit LFSR.
  burst_len  in  16  number of words to send and to check.
  tx_ready  in  1  the downstream transmit FIFO can accept a word.
  tx_write  out  1  write strobe into the transmit FIFO.
  tx_data  out  32  word being written.
  rx_valid  in  1  the receive FIFO head word is valid.
  rx_data  in  32  receive FIFO head word.
  rx_read  out  1  pop strobe for the receive FIFO.
  busy  out  1  a burst is in progress.
  done  out  1  single-cycle pulse at burst end.
  err_count  out  16  number of mismatched received words.
  err_flag  out  1  sticky flag for any mismatch.
  timeout  out  1  the burst was terminated by the timeout.

Function
REQ-004 SHALL implement FSM states IDLE, RUN, DONE.
REQ-005 IDLE->RUN on start=1 with burst_len!=0; IDLE->DONE on start=1 with burst_len==0.
REQ-006 On accepted start SHALL latch burst_len and mode, load both generators with SEED, and clear tx/rx word counters, err_count, err_flag, timeout.
REQ-007 start in RUN or DONE SHALL be ignored.
REQ-008 RUN: tx_write = tx_ready && tx_cnt<len, combinationally; tx_data = the TX generator's current word.
REQ-009 Each tx_write cycle SHALL increment tx_cnt and advance the TX generator; the next word is available the following cycle (one word per cycle maximum).
REQ-010 Generator advance rule: mode 0 adds 1 modulo 2^32 (32'hFFFF_FFFF wraps to 0); mode 1 performs a Galois LFSR step with polynomial x^32+x^22+x^2+x+1. A SEED of 0 SHALL be loaded as 1 in mode 1.
REQ-011 RUN: rx_read = rx_valid && rx_cnt<len, combinationally; on an rx_read cycle rx_data SHALL be compared to the RX generator's current word, rx_cnt incremented, and the RX generator advanced.
REQ-012 A mismatch SHALL increment err_count, saturating at 16'hFFFF, and set err_flag.
REQ-013 Transmit and receive SHALL progress independently; a tx_write and an rx_read in the same cycle are both honoured.
REQ-014 RUN->DONE when tx_cnt==len and rx_cnt==len, evaluated after the current cycle's updates.
REQ-015 DONE SHALL last exactly one cycle with done=1, then go to IDLE; err_count, err_flag and timeout hold until the next accepted start.
REQ-016 busy=1 exactly in RUN; tx_write=rx_read=0 outside RUN.

Reset
REQ-017 rst=0 SHALL asynchronously force IDLE, all counters to 0, generators to SEED, and tx_write, rx_read, busy, done, err_count, err_flag, timeout to 0, including mid-burst.
REQ-018 Release of rst SHALL start no activity until a start pulse.

Configuration
REQ-019 With macro PATTERN_TIMEOUT_EN defined, a 24-bit counter in RUN SHALL clear on each rx_read and otherwise increment; on reaching TIMEOUT_CYCLES it SHALL set timeout=1 and force RUN->DONE.
REQ-020 Without PATTERN_TIMEOUT_EN, the counter SHALL be absent, timeout SHALL be tied 0, and RUN exits only per REQ-014.

Verification
REQ-021 Bench scenario: mode 0, SEED=0, len=4, tx_ready=1, loopback FIFO -> tx_data 0,1,2,3; done pulse; err_count=0.
REQ-022 Bench scenario: mode 1, len=3 -> words SEED, lfsr(SEED), lfsr^2(SEED), checked against a reference model; err_flag=0.
REQ-023 Bench scenario: the second received word is corrupted by XOR 32'h1 -> err_count=1, err_flag=1 held after done.
REQ-024 Bench scenario: tx_ready toggles every cycle and rx_valid stalls for 10 cycles -> no extra writes or reads; exactly len of each.
REQ-025 Bench scenario: start with len=0 -> done on the next cycle, no tx_write; rst pulsed mid-burst -> all outputs 0 immediately.
REQ-026 Bench scenario: with PATTERN_TIMEOUT_EN and TIMEOUT_CYCLES=16, rx_valid held 0 -> done and timeout=1 after 16 cycles.
